// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the multi-port register file.
package regfile_pkg;

  localparam logic        WriteEnable = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam logic        RstEnable   = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: bypass priority mux, zero-register masking, optional output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned RD_REG   = 0,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     blank,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]        array_data,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] value;

  // Later masks override earlier sources, so the highest-priority rule is applied last.
  always_comb begin
    value = array_data;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (we[i] == WriteEnable && waddr[i*ADDR_W +: ADDR_W] == raddr) begin
        value = wdata[i*DATA_W +: DATA_W];
      end
    end
    if (ZERO_REG != 0 && raddr == ADDR_W'(0)) value = DATA_W'(ZeroWord);
    if (re != ReadEnable)                     value = DATA_W'(ZeroWord);
    if (blank)                                value = DATA_W'(ZeroWord);
  end

  generate
    if (RD_REG != 0) begin : g_reg
      // Registered read: one-cycle copy of the resolved value.
      always_ff @(posedge clk) begin
        rdata <= value;
      end
    end else begin : g_comb
      assign rdata = value;
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass and a hardware clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned RD_REG   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     init_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     wr_conflict
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  rf_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              write_ok;
  logic              blank;
  logic [NUM_WR-1:0] we_eff;
  logic              conflict_c;

  // State and sweep counter; reset restarts the sweep from zero.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Sweep advances one register per cycle; clr is only honoured in READY.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      CLEAR: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DEPTH - 1)) state_next = READY;
      end
      READY: begin
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign init_busy = (state == CLEAR);
  assign blank     = (state == CLEAR) || (rst == RstEnable);
  assign write_ok  = (state == READY) && !clr && (rst != RstEnable);

  // Qualified write enables: drop writes outside READY and writes to a hardwired r0.
  always_comb begin
    we_eff = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      we_eff[i] = (we[i] == WriteEnable) && write_ok &&
                  !(ZERO_REG != 0 && waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(0));
    end
  end

  // Storage: sweep zeroing, else writes in port order so the highest index wins.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[cnt[ADDR_W-1:0]] <= DATA_W'(ZeroWord);
    end else begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (we_eff[i]) regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Any pair of accepted writes to the same address is a conflict.
  always_comb begin
    conflict_c = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR; j++) begin
        if (we_eff[i] && we_eff[j] &&
            waddr[i*ADDR_W +: ADDR_W] == waddr[j*ADDR_W +: ADDR_W]) begin
          conflict_c = 1'b1;
        end
      end
    end
  end

  // Conflict flag lags the colliding writes by one cycle.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) wr_conflict <= 1'b0;
    else                  wr_conflict <= conflict_c;
  end

  generate
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      regfile_rd_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_WR  (NUM_WR),
        .RD_REG  (RD_REG),
        .ZERO_REG(ZERO_REG)
      ) u_rd (
        .clk       (clk),
        .blank     (blank),
        .re        (re[j]),
        .raddr     (raddr[j*ADDR_W +: ADDR_W]),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .array_data(regs[raddr[j*ADDR_W +: ADDR_W]]),
        .rdata     (rdata[j*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: instance a = combinational reads with hardwired r0,
// instance b = registered reads with a writable r0; both share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [1:0]  we, re;
  logic [9:0]  waddr, raddr;
  logic [63:0] wdata;
  logic        init_busy_a, init_busy_b, wr_conflict_a, wr_conflict_b;
  logic [63:0] rdata_a, rdata_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .RD_REG(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .init_busy(init_busy_a),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_a), .wr_conflict(wr_conflict_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0), .RD_REG(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .init_busy(init_busy_b),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_b), .wr_conflict(wr_conflict_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with init_busy high; optionally poke a write mid-sweep.
  task automatic count_sweep(input bit poke, output int cnt_out);
    int c;
    c = 0;
    while (init_busy_a && c < 100) begin
      if (poke && c == 5) begin
        we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'hAAAA5555;
        re = 2'b01; raddr[4:0] = 5'd3;
        #1;
        check("sweep_rd", 64'(rdata_a[31:0]), 64'h0);
        check("sweep_conf", 64'(wr_conflict_a), 64'h0);
      end
      if (poke && c == 6) we = 2'b00;
      tick();
      c++;
    end
    cnt_out = c;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = '0; re = 2'b11;
    waddr = '0; raddr = '0; wdata = '0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", 64'(init_busy_a), 64'h1);
    check("rst_conf", 64'(wr_conflict_a), 64'h0);
    check("rst_rd_a", rdata_a, 64'h0);
    check("rst_rd_b", rdata_b, 64'h0);

    // Sweep after reset release, with a dropped write at sweep cycle 5
    rst = 1'b0;
    count_sweep(1'b1, n);
    check("sweep_len", 64'(n), 64'd32);
    check("busy_done", 64'(init_busy_a), 64'h0);

    // All registers read zero after the sweep (r3 proves the sweep write was dropped)
    re = 2'b01;
    for (int a = 1; a < 32; a++) begin
      raddr[4:0] = 5'(a);
      #1;
      check("post_sweep_rd", 64'(rdata_a[31:0]), 64'h0);
    end

    // Bypass: same cycle on a, one cycle later on b
    raddr[4:0] = 5'd3;
    tick();
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF; raddr[4:0] = 5'd5;
    #1;
    check("byp_a", 64'(rdata_a[31:0]), 64'hDEADBEEF);
    check("byp_b_pre", 64'(rdata_b[31:0]), 64'h0);
    tick();
    we = 2'b00;
    #1;
    check("byp_b", 64'(rdata_b[31:0]), 64'hDEADBEEF);
    check("array_a", 64'(rdata_a[31:0]), 64'hDEADBEEF);

    // Write collision on r7
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22222222, 32'h11111111}; raddr[4:0] = 5'd7;
    #1;
    check("coll_byp", 64'(rdata_a[31:0]), 64'h22222222);
    check("coll_conf0", 64'(wr_conflict_a), 64'h0);
    tick();
    we = 2'b00;
    #1;
    check("coll_conf_a", 64'(wr_conflict_a), 64'h1);
    check("coll_conf_b", 64'(wr_conflict_b), 64'h1);
    check("coll_rd", 64'(rdata_a[31:0]), 64'h22222222);
    tick();
    check("coll_conf_end", 64'(wr_conflict_a), 64'h0);

    // Zero register: both ports write r0
    we = 2'b11; waddr = {5'd0, 5'd0}; wdata = {32'hFFFFFFFF, 32'hFFFFFFFF}; raddr[4:0] = 5'd0;
    #1;
    check("r0_byp_a", 64'(rdata_a[31:0]), 64'h0);
    tick();
    we = 2'b00;
    #1;
    check("r0_conf_a", 64'(wr_conflict_a), 64'h0);
    check("r0_conf_b", 64'(wr_conflict_b), 64'h1);
    tick();
    check("r0_rd_a", 64'(rdata_a[31:0]), 64'h0);
    check("r0_rd_b", 64'(rdata_b[31:0]), 64'hFFFFFFFF);

    // Fill r1..r31 through port 1
    for (int a = 1; a < 32; a++) begin
      we = 2'b10; waddr[9:5] = 5'(a); wdata[63:32] = 32'hA5000000 | 32'(a);
      tick();
    end
    we = 2'b00; re = 2'b10;
    raddr[9:5] = 5'd1;
    #1;
    check("fill_r1", 64'(rdata_a[63:32]), 64'hA5000001);
    raddr[9:5] = 5'd31;
    #1;
    check("fill_r31", 64'(rdata_a[63:32]), 64'hA500001F);

    // Soft clear, with a same-cycle write that must be dropped
    clr = 1'b1; we = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h12345678;
    tick();
    clr = 1'b0; we = 2'b00; re = 2'b01; raddr[4:0] = 5'd31;
    #1;
    check("clr_busy", 64'(init_busy_a), 64'h1);
    check("clr_rd", 64'(rdata_a[31:0]), 64'h0);
    count_sweep(1'b0, n);
    check("clr_len", 64'(n), 64'd32);
    for (int a = 0; a < 32; a++) begin
      raddr[4:0] = 5'(a);
      #1;
      check("clr_after", 64'(rdata_a[31:0]), 64'h0);
    end
    raddr[4:0] = 5'd0;
    tick();
    check("clr_r0_b", 64'(rdata_b[31:0]), 64'h0);

    // Reset at sweep cycle 10 restarts the sweep
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    check("mid_busy", 64'(init_busy_a), 64'h1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    count_sweep(1'b0, n);
    check("rst_mid_len", 64'(n), 64'd32);
    check("rst_mid_done", 64'(init_busy_a), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
